// File: rtl/ryu_action_ctrl.sv
// Purpose: frame-rate pose/position state machine for the Ryu sprite (STAND/WALK/CROUCH/PUNCH/JUMP).
// Latency: buttons sampled on a frame_tick edge; sprite/RyuX/RyuY/punch_active valid the next cycle.
// Backpressure: none; paced purely by frame_tick, all state holds between ticks.
module ryu_action_ctrl #(
  parameter int X_INIT       = 100,
  parameter int Y_GROUND     = 300,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 540,
  parameter int WALK_STEP    = 2,
  parameter int PUNCH_FRAMES = 12,
  parameter int JUMP_V0      = 12,
  parameter int GRAVITY      = 1
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_punch,
  output logic [2:0] sprite,
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic       punch_active
);

  // State codes double as the sprite pose codes.
  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_PUNCH  = 3'd1,
    ST_JUMP   = 3'd2,
    ST_CROUCH = 3'd3,
    ST_WALK_L = 3'd4,
    ST_WALK_R = 3'd5
  } state_t;

  localparam int CNT_W = (PUNCH_FRAMES > 1) ? $clog2(PUNCH_FRAMES) : 1;

  // Position math is done signed and wider than the 10-bit outputs so that
  // stepping past either edge is clamped rather than wrapping.
  localparam logic signed [11:0] XMIN_S  = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S  = 12'(X_MAX);
  localparam logic signed [11:0] STEP_S  = 12'(WALK_STEP);
  localparam logic signed [11:0] YG_S    = 12'(Y_GROUND);
  localparam logic signed [7:0]  V0_S    = 8'(JUMP_V0);
  localparam logic signed [7:0]  GRAV_S  = 8'(GRAVITY);
  localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(PUNCH_FRAMES - 1);

  function automatic logic [9:0] clamp_x(input logic signed [11:0] v);
    if (v < XMIN_S) begin
      clamp_x = XMIN_S[9:0];
    end else if (v > XMAX_S) begin
      clamp_x = XMAX_S[9:0];
    end else begin
      clamp_x = v[9:0];
    end
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            sprite_q, sprite_d;
  logic [9:0]            x_q, x_d;
  logic [9:0]            y_q, y_d;
  logic                  punch_q, punch_d;
  logic signed [7:0]     vel_q, vel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic signed [11:0]    drift_q, drift_d;

  logic                  excl_l;
  logic                  excl_r;
  state_t                ground_next;
  logic signed [11:0]    x_ext;
  logic [9:0]            x_walk_l;
  logic [9:0]            x_walk_r;
  logic [9:0]            x_drift;
  logic signed [11:0]    y_new;
  logic signed [7:0]     vel_next;

  // Button priority for the grounded states: punch > up > down > left-only > right-only.
  always_comb begin
    excl_l = btn_left & ~btn_right;
    excl_r = btn_right & ~btn_left;
    if (btn_punch) begin
      ground_next = ST_PUNCH;
    end else if (btn_up) begin
      ground_next = ST_JUMP;
    end else if (btn_down) begin
      ground_next = ST_CROUCH;
    end else if (excl_l) begin
      ground_next = ST_WALK_L;
    end else if (excl_r) begin
      ground_next = ST_WALK_R;
    end else begin
      ground_next = ST_STAND;
    end
  end

  // Candidate positions and jump kinematics for this tick.
  always_comb begin
    x_ext    = $signed({2'b00, x_q});
    x_walk_l = clamp_x(x_ext - STEP_S);
    x_walk_r = clamp_x(x_ext + STEP_S);
    x_drift  = clamp_x(x_ext + drift_q);
    y_new    = $signed({2'b00, y_q}) - $signed({{4{vel_q[7]}}, vel_q});
    vel_next = vel_q - GRAV_S;
  end

  // Next-state logic; nothing moves unless frame_tick is high.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vel_d   = vel_q;
    cnt_d   = cnt_q;
    drift_d = drift_q;
    if (frame_tick) begin
      case (state_q)
        ST_STAND, ST_CROUCH, ST_WALK_L, ST_WALK_R: begin
          state_d = ground_next;
          y_d     = YG_S[9:0];
          case (ground_next)
            ST_WALK_L: x_d = x_walk_l;
            ST_WALK_R: x_d = x_walk_r;
            ST_PUNCH:  cnt_d = CNT_TOP;
            ST_JUMP: begin
              // Y stays on the ground this tick; only the pose changes.
              vel_d = V0_S;
              if (excl_l) begin
                drift_d = -STEP_S;
              end else if (excl_r) begin
                drift_d = STEP_S;
              end else begin
                drift_d = '0;
              end
            end
            default: ;
          endcase
        end
        ST_PUNCH: begin
          if (cnt_q == '0) begin
            state_d = ST_STAND;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_JUMP: begin
          x_d   = x_drift;
          vel_d = vel_next;
          if ((vel_q <= 8'sd0) && (y_new >= YG_S)) begin
            y_d     = YG_S[9:0];
            state_d = ST_STAND;
            vel_d   = '0;
            drift_d = '0;
          end else if (y_new < 12'sd0) begin
            // A very large launch velocity would leave the top of the screen.
            y_d = '0;
          end else begin
            y_d = y_new[9:0];
          end
        end
        default: begin
          state_d = ST_STAND;
          y_d     = YG_S[9:0];
        end
      endcase
    end
    sprite_d = state_d;
    punch_d  = (state_d == ST_PUNCH);
  end

  // Single state register with registered pose/position outputs; reset wins over frame_tick.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q  <= ST_STAND;
      sprite_q <= 3'd0;
      x_q      <= 10'(X_INIT);
      y_q      <= 10'(Y_GROUND);
      punch_q  <= 1'b0;
      vel_q    <= '0;
      cnt_q    <= '0;
      drift_q  <= '0;
    end else begin
      state_q  <= state_d;
      sprite_q <= sprite_d;
      x_q      <= x_d;
      y_q      <= y_d;
      punch_q  <= punch_d;
      vel_q    <= vel_d;
      cnt_q    <= cnt_d;
      drift_q  <= drift_d;
    end
  end

  assign sprite       = sprite_q;
  assign RyuX         = x_q;
  assign RyuY         = y_q;
  assign punch_active = punch_q;

endmodule

// File: tb/tb_ryu_action_ctrl.sv
// Purpose: scoreboard bench for ryu_action_ctrl using directed button sequences.
// Latency: one expected record per reset or frame_tick edge, checked #1 after that edge.
// Backpressure: none; stimulus pushes expectations, an independent monitor pops them.
module tb_ryu_action_ctrl;

  typedef struct {
    logic [2:0] s;
    logic [9:0] x;
    logic [9:0] y;
    logic       p;
  } exp_t;

  // Button masks: {left, right, up, down, punch}
  localparam logic [4:0] B_L = 5'b10000;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_U = 5'b00100;
  localparam logic [4:0] B_D = 5'b00010;
  localparam logic [4:0] B_P = 5'b00001;
  localparam logic [4:0] B_0 = 5'b00000;

  logic       vga_clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic       btn_left, btn_right, btn_up, btn_down, btn_punch;
  logic [2:0] sprite;
  logic [9:0] RyuX, RyuY;
  logic       punch_active;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   stim_done = 1'b0;

  // Hand-computed jump heights after jump ticks 1..25 (V0=12, gravity 1).
  int ytab [0:24] = '{288, 277, 267, 258, 250, 243, 237, 232, 228, 225,
                      223, 222, 222, 223, 225, 228, 232, 237, 243, 250,
                      258, 267, 277, 288, 300};

  always #5 vga_clk = ~vga_clk;

  ryu_action_ctrl dut (
    .vga_clk      (vga_clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_punch    (btn_punch),
    .sprite       (sprite),
    .RyuX         (RyuX),
    .RyuY         (RyuY),
    .punch_active (punch_active)
  );

  task automatic set_btn(input logic [4:0] b);
    {btn_left, btn_right, btn_up, btn_down, btn_punch} = b;
  endtask

  task automatic push_exp(input logic [2:0] s, input int x, input int y, input logic p);
    exp_t e;
    e.s = s;
    e.x = 10'(x);
    e.y = 10'(y);
    e.p = p;
    exp_q.push_back(e);
  endtask

  // One frame tick with buttons b, then `gap` idle cycles with noise on the buttons.
  task automatic tick(input logic [4:0] b, input logic [2:0] s, input int x, input int y,
                      input logic p, input int gap);
    @(negedge vga_clk);
    set_btn(b);
    frame_tick = 1'b1;
    push_exp(s, x, y, p);
    @(negedge vga_clk);
    frame_tick = 1'b0;
    for (int g = 0; g < gap; g++) begin
      set_btn(5'($urandom_range(0, 31)));
      @(negedge vga_clk);
    end
  endtask

  // One-cycle reset, asserted together with a tick and buttons to show reset wins.
  task automatic do_reset();
    @(negedge vga_clk);
    Reset      = 1'b1;
    frame_tick = 1'b1;
    set_btn(B_R | B_U);
    push_exp(3'd0, 100, 300, 1'b0);
    @(negedge vga_clk);
    Reset      = 1'b0;
    frame_tick = 1'b0;
    set_btn(B_0);
  endtask

  // Monitor: every reset or tick edge produces one output update to check.
  initial begin
    exp_t e;
    forever begin
      @(posedge vga_clk);
      if (Reset === 1'b1 || frame_tick === 1'b1) begin
        #1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update: got sprite=%0d x=%0d y=%0d pa=%0b, no expectation queued",
                   sprite, RyuX, RyuY, punch_active);
        end else begin
          e = exp_q.pop_front();
          if (sprite !== e.s || RyuX !== e.x || RyuY !== e.y || punch_active !== e.p) begin
            errors++;
            $display("FAIL update%0d: got sprite=%0d x=%0d y=%0d pa=%0b, expected sprite=%0d x=%0d y=%0d pa=%0b",
                     checks, sprite, RyuX, RyuY, punch_active, e.s, e.x, e.y, e.p);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int x;
    Reset      = 1'b0;
    frame_tick = 1'b0;
    set_btn(B_0);

    // Reset state then idle ticks
    do_reset();
    for (int i = 0; i < 5; i++) tick(B_0, 3'd0, 100, 300, 1'b0, i % 3);

    // Walk right to the right clamp and hold there
    for (int k = 1; k <= 300; k++) begin
      x = 100 + 2 * k;
      if (x > 540) x = 540;
      tick(B_R, 3'd5, x, 300, 1'b0, k % 3);
    end
    tick(B_0, 3'd0, 540, 300, 1'b0, 1);

    // Walk left a bit, then a punch while left stays held
    for (int k = 1; k <= 10; k++) tick(B_L, 3'd4, 540 - 2 * k, 300, 1'b0, 1);
    tick(B_L | B_P, 3'd1, 520, 300, 1'b1, 1);
    for (int k = 1; k <= 11; k++)
      tick((k == 5) ? (B_L | B_U) : B_L, 3'd1, 520, 300, 1'b1, k % 2);
    tick(B_L, 3'd0, 520, 300, 1'b0, 1);
    tick(B_L, 3'd4, 518, 300, 1'b0, 1);
    tick(B_0, 3'd0, 518, 300, 1'b0, 1);

    // Jump right from X=100; buttons mid-air are ignored
    do_reset();
    tick(B_U | B_R, 3'd2, 100, 300, 1'b0, 1);
    for (int j = 1; j <= 25; j++)
      tick((j == 5) ? B_P : ((j == 8) ? (B_L | B_U) : B_0),
           (j < 25) ? 3'd2 : 3'd0, 100 + 2 * j, ytab[j-1], 1'b0, j % 2);

    // Both directions cancel; down has priority over them
    tick(B_L | B_R, 3'd0, 150, 300, 1'b0, 1);
    tick(B_L | B_R, 3'd0, 150, 300, 1'b0, 2);
    tick(B_L | B_R | B_D, 3'd3, 150, 300, 1'b0, 1);
    tick(B_L | B_R | B_D, 3'd3, 150, 300, 1'b0, 1);
    tick(B_L | B_R, 3'd0, 150, 300, 1'b0, 1);

    // Reset in the middle of a left jump
    tick(B_U | B_L, 3'd2, 150, 300, 1'b0, 1);
    for (int j = 1; j <= 10; j++) tick(B_0, 3'd2, 150 - 2 * j, ytab[j-1], 1'b0, 1);
    do_reset();
    tick(B_R, 3'd5, 102, 300, 1'b0, 1);

    // Walk into the left clamp
    for (int k = 1; k <= 60; k++) begin
      x = 102 - 2 * k;
      if (x < 0) x = 0;
      tick(B_L, 3'd4, x, 300, 1'b0, k % 3);
    end

    // Jump with left drift while at the left edge: X stays clamped
    tick(B_U | B_L, 3'd2, 0, 300, 1'b0, 1);
    for (int j = 1; j <= 25; j++) tick(B_L, (j < 25) ? 3'd2 : 3'd0, 0, ytab[j-1], 1'b0, 1);
    tick(B_D | B_L, 3'd3, 0, 300, 1'b0, 1);
    tick(B_L, 3'd4, 0, 300, 1'b0, 1);
    tick(B_P, 3'd1, 0, 300, 1'b1, 2);

    stim_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report
  initial begin
    int budget;
    wait (stim_done);
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge vga_clk);
      budget++;
    end
    repeat (3) @(negedge vga_clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
